// File: rtl/fpu_ss_pkg.sv
// rtl/fpu_ss_pkg.sv - shared state, entry types and defaults for the FPU CSR sequencer
package fpu_ss_pkg;

  localparam int unsigned FPU_SS_DEPTH    = 2;
  localparam int unsigned FPU_SS_ID_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_ISSUE,
    ST_RESP
  } seq_state_e;

  // Id-independent part of a queued entry; the id is appended in the top because its width is a parameter.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [4:0]  rd;
  } csr_entry_t;

endpackage

// File: rtl/fpu_ss_fifo.sv
// rtl/fpu_ss_fifo.sv - generic FIFO with wrap-around pointers and occupancy counter
module fpu_ss_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (r_count == CNT_W'(DEPTH));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign data_o  = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/fpu_ss_csr_sequencer.sv
// rtl/fpu_ss_csr_sequencer.sv - queues CSR instructions and issues them one at a time to fpu_ss_csr
// Define FPU_SS_CSR_DRAIN_EN to hold issue until the FPU pipeline reports idle.
module fpu_ss_csr_sequencer
  import fpu_ss_pkg::*;
#(
  parameter int unsigned DEPTH    = FPU_SS_DEPTH,
  parameter int unsigned ID_WIDTH = FPU_SS_ID_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [31:0]         in_instr_i,
  input  logic [31:0]         in_rs1_i,
  input  logic [ID_WIDTH-1:0] in_id_i,
  input  logic [4:0]          in_rd_i,
  input  logic                fpu_busy_i,
  output logic [31:0]         csr_instr_o,
  output logic [31:0]         csr_data_o,
  input  logic [31:0]         csr_rdata_i,
  input  logic                csr_wb_i,
  input  logic                csr_instr_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [ID_WIDTH-1:0] res_id_o,
  output logic [4:0]          res_rd_o,
  output logic [31:0]         res_data_o,
  output logic                res_we_o,
  output logic                res_illegal_o
);

  localparam int unsigned ENTRY_W = $bits(csr_entry_t) + ID_WIDTH;

  seq_state_e          r_state;
  seq_state_e          w_state_next;
  logic                w_issue;
  logic                w_full;
  logic                w_empty;
  csr_entry_t          w_in_entry;
  csr_entry_t          w_head_entry;
  logic [ID_WIDTH-1:0] w_head_id;
  logic [ENTRY_W-1:0]  w_fifo_wdata;
  logic [ENTRY_W-1:0]  w_fifo_rdata;

  assign w_in_entry   = '{instr: in_instr_i, rs1: in_rs1_i, rd: in_rd_i};
  assign w_fifo_wdata = {w_in_entry, in_id_i};
  assign {w_head_entry, w_head_id} = w_fifo_rdata;
  assign in_ready_o   = !w_full;

  fpu_ss_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (in_valid_i),
    .data_i  (w_fifo_wdata),
    .pop_i   (w_issue),
    .data_o  (w_fifo_rdata),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

`ifndef FPU_SS_CSR_DRAIN_EN
  logic w_unused_busy;
  assign w_unused_busy = fpu_busy_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
`ifdef FPU_SS_CSR_DRAIN_EN
          w_state_next = fpu_busy_i ? ST_DRAIN : ST_ISSUE;
`else
          w_state_next = ST_ISSUE;
`endif
        end
      end
`ifdef FPU_SS_CSR_DRAIN_EN
      ST_DRAIN: begin
        if (!fpu_busy_i) w_state_next = ST_ISSUE;
      end
`endif
      ST_ISSUE: begin
        w_issue      = 1'b1;
        w_state_next = ST_RESP;
      end
      ST_RESP: begin
        if (res_ready_i) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Zero outside ISSUE is a non-CSR encoding, so the CSR block never commits stray writes.
  assign csr_instr_o = w_issue ? w_head_entry.instr : '0;
  assign csr_data_o  = w_issue ? w_head_entry.rs1   : '0;
  assign res_valid_o = (r_state == ST_RESP);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_id_o      <= '0;
      res_rd_o      <= '0;
      res_data_o    <= '0;
      res_we_o      <= 1'b0;
      res_illegal_o <= 1'b0;
    end else if (w_issue) begin
      res_id_o      <= w_head_id;
      res_rd_o      <= w_head_entry.rd;
      res_data_o    <= csr_rdata_i;
      res_we_o      <= csr_wb_i && (w_head_entry.rd != 5'd0);
      res_illegal_o <= !csr_instr_i;
    end
  end

endmodule

// File: doc/fpu_ss_csr_sequencer.md
# fpu_ss_csr_sequencer

Sequencing stage directly upstream of the FPU subsystem CSR block (`fpu_ss_csr`). It accepts offloaded CSR-class instructions with their rs1 operand, id and rd into a small FIFO. Before issuing an instruction it waits until the FPU pipeline has drained, so an `frm` change never affects in-flight operations. It drives the CSR block for exactly one cycle per instruction, then holds the captured read data on a valid/ready result port for integer writeback.

## Interface
Parameters:
- `DEPTH`, 2: FIFO entries; must be ≥1.
- `ID_WIDTH`, 4: width of the offload instruction id.

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset; asynchronous, active-low
- `in_valid_i`  in  1  offered CSR instruction valid
- `in_ready_o`  out  1  FIFO can accept
- `in_instr_i`  in  32  instruction word
- `in_rs1_i`  in  32  rs1 operand value
- `in_id_i`  in  ID_WIDTH  instruction id
- `in_rd_i`  in  5  destination integer register
- `fpu_busy_i`  in  1  FPU has at least one operation in flight
- `csr_instr_o`  out  32  instruction to CSR block; 0 when not issuing
- `csr_data_o`  out  32  rs1 operand to CSR block; 0 when not issuing
- `csr_rdata_i`  in  32  CSR block read data
- `csr_wb_i`  in  1  CSR block requests integer writeback
- `csr_instr_i`  in  1  CSR block recognised the instruction
- `res_valid_o`  out  1  result valid
- `res_ready_i`  in  1  result accepted
- `res_id_o`  out  ID_WIDTH  result id
- `res_rd_o`  out  5  result rd
- `res_data_o`  out  32  result data
- `res_we_o`  out  1  integer register write enable
- `res_illegal_o`  out  1  instruction not recognised by the CSR block

## Operation
- FIFO entry = {instr, rs1, id, rd}.
- Push when `in_valid_i && in_ready_o`. `in_ready_o = !full`, independent of pop.
- Read and write pointers wrap from DEPTH-1 to 0. An occupancy counter spans 0..DEPTH.
- FSM states: IDLE, DRAIN, ISSUE, RESP.
  - IDLE: if FIFO non-empty, go to ISSUE if `!fpu_busy_i`, otherwise to DRAIN. If empty, stay.
  - DRAIN: go to ISSUE in the first cycle `fpu_busy_i`=0.
  - ISSUE (exactly 1 cycle):
    - Drive the head entry on `csr_instr_o`/`csr_data_o`.
    - Capture `csr_rdata_i` into `res_data_o`.
    - `res_we_o` = `csr_wb_i && rd!=0`.
    - `res_illegal_o` = `!csr_instr_i`.
    - Latch the head id and rd. Pop the head. Go to RESP.
  - RESP: `res_valid_o`=1. Hold every res_* output stable until `res_ready_i`, then go to IDLE.
- Outside ISSUE, `csr_instr_o` and `csr_data_o` are 0. 0 is a non-CSR encoding, so the CSR block commits nothing.
- Only one instruction is outstanding at a time. Order is preserved.
- A simultaneous push and pop in ISSUE is allowed; occupancy stays unchanged.
- Unrecognised instructions still complete through RESP, with `res_we_o`=0 and `res_illegal_o`=1.

## Timing
- Reset values:
  - FSM = IDLE, FIFO empty, `in_ready_o`=1.
  - `csr_instr_o`, `csr_data_o` = 0.
  - `res_valid_o`, `res_we_o`, `res_illegal_o` = 0.
  - `res_id_o`, `res_rd_o`, `res_data_o` = 0.
- Best-case latency (FIFO empty, FPU idle):
  - Push at edge T0.
  - Cycle T0+1: IDLE.
  - Cycle T0+2: ISSUE.
  - Cycle T0+3: `res_valid_o`=1.
- Back-to-back: the next ISSUE comes no earlier than 2 cycles after the RESP handshake cycle.
- Full FIFO: `in_ready_o`=0; offered data must be held by the sender.
- Reset asserted mid-operation:
  - All state clears asynchronously.
  - Queued entries are discarded.
  - `csr_instr_o` returns to 0 immediately.

## Configuration
- `FPU_SS_CSR_DRAIN_EN` defined: the DRAIN behaviour described above.
- Undefined:
  - `fpu_busy_i` is ignored and the DRAIN state is not compiled.
  - IDLE with a non-empty FIFO goes straight to ISSUE.
  - Latency is always the best case.

## Structure
- `fpu_ss_pkg` holds the FSM state enum typedef, the FIFO entry struct typedef, and the `DEPTH`/`ID_WIDTH` defaults.
- One sub-module: `fpu_ss_fifo`, a generic parameterised FIFO with push/pop, full/empty and wrap-around pointers. The FSM lives in the top module.

## Test plan
- FCSR write path: reset, `fpu_busy_i`=0, push `csrrw x5, fcsr, x6` with rs1=0x000000E1, id=3.
  - Response: ISSUE 2 cycles after push.
  - Result: `res_valid_o` with data 0, rd=5, id=3, `res_we_o`=1.
  - A following `frcsr` returns 0xE1.
- Drain wait: hold `fpu_busy_i`=1 for 10 cycles, push `fsrm`.
  - `csr_instr_o` stays 0 throughout.
  - ISSUE occurs 1 cycle after busy falls.
- Full FIFO with backpressure: push DEPTH+1 instructions with `res_ready_i`=0.
  - `in_ready_o` drops after DEPTH pushes.
  - The result stays held while ready is low.
  - Releasing ready drains the results in order, with ids matching.
- Write suppression and illegal: push with rd=0 → `res_we_o`=0. Push 0x00000013 (NOP) → `res_illegal_o`=1, `res_we_o`=0.
- Mid-operation reset: assert `rst_ni` low in DRAIN with 2 entries queued.
  - All outputs go to their reset values immediately.
  - After release, a new push completes normally.
